// File: rtl/req_collector.sv
// rtl/req_collector.sv - per-client pending-request accumulator feeding rr_arbiter
module req_collector #(
    parameter int CLIENTS = 32,
    parameter int CNT_W   = 2,
    parameter int TOT_W   = $clog2(CLIENTS * ((1 << CNT_W) - 1) + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CLIENTS-1:0] post,
    output logic [CLIENTS-1:0] full,
    output logic [CLIENTS-1:0] request,
    input  logic [CLIENTS-1:0] grant,
    input  logic               downstream_ready,
    output logic               stall,
    output logic [TOT_W-1:0]   total_pending,
    output logic               overflow,
    output logic               grant_err
);

    localparam logic [CNT_W-1:0] MAX_PEND = '1;

    logic [CNT_W-1:0]   count_q [CLIENTS];
    logic [CNT_W-1:0]   count_d [CLIENTS];
    logic               stall_q, stall_d;
    logic [TOT_W-1:0]   total_pending_q, total_pending_d;
    logic               overflow_q, overflow_d;
    logic               grant_err_q, grant_err_d;

    logic [CLIENTS-1:0] g_ok;
    logic [CLIENTS-1:0] a_ok;
    logic [TOT_W-1:0]   add_n;
    logic [TOT_W-1:0]   sub_n;
    logic               multi_grant;

    // full and request depend only on the registered counts, never on post/grant
    always_comb begin
        full    = '0;
        request = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            full[i]    = (count_q[i] == MAX_PEND);
            request[i] = (count_q[i] != '0);
        end
    end

    // next-state: accept/retire per client, running total and sticky error flags
    always_comb begin
        g_ok        = grant & request & {CLIENTS{~stall_q}};
        a_ok        = post & (~full | g_ok);
        add_n       = '0;
        sub_n       = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            count_d[i] = count_q[i];
            if (a_ok[i] && !g_ok[i]) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end else if (g_ok[i] && !a_ok[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
            add_n = add_n + TOT_W'(a_ok[i]);
            sub_n = sub_n + TOT_W'(g_ok[i]);
        end
        total_pending_d = total_pending_q + add_n - sub_n;
        // x & (x-1) is non-zero exactly when more than one bit is set
        multi_grant     = |(grant & (grant - CLIENTS'(1)));
        overflow_d      = overflow_q | (|(post & ~a_ok));
        grant_err_d     = grant_err_q | multi_grant
                        | ((|grant) & stall_q)
                        | (|(grant & ~request));
        stall_d         = ~downstream_ready;
    end

    // state registers; reset drops all pending work immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLIENTS; i++) begin
                count_q[i] <= '0;
            end
            stall_q         <= 1'b1;
            total_pending_q <= '0;
            overflow_q      <= 1'b0;
            grant_err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                count_q[i] <= count_d[i];
            end
            stall_q         <= stall_d;
            total_pending_q <= total_pending_d;
            overflow_q      <= overflow_d;
            grant_err_q     <= grant_err_d;
        end
    end

    assign stall         = stall_q;
    assign total_pending = total_pending_q;
    assign overflow      = overflow_q;
    assign grant_err     = grant_err_q;

endmodule

// File: tb/tb_req_collector.sv
// tb/tb_req_collector.sv - scoreboard bench for req_collector
module tb_req_collector;

    logic        clk;
    logic        rst_n;
    logic [31:0] post;
    logic [31:0] full;
    logic [31:0] request;
    logic [31:0] grant;
    logic        downstream_ready;
    logic        stall;
    logic [6:0]  total_pending;
    logic        overflow;
    logic        grant_err;

    req_collector dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .post             (post),
        .full             (full),
        .request          (request),
        .grant            (grant),
        .downstream_ready (downstream_ready),
        .stall            (stall),
        .total_pending    (total_pending),
        .overflow         (overflow),
        .grant_err        (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] req;
        logic [31:0] full;
        logic [6:0]  tot;
        logic        stall;
        logic        ovf;
        logic        gerr;
    } exp_t;

    exp_t exp_q[$];

    int passed = 0;
    int total  = 0;

    int m_cnt[32];
    bit m_stall;
    bit m_ovf;
    bit m_gerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_stall = 1'b1;
        m_ovf   = 1'b0;
        m_gerr  = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] p, input logic [31:0] g, input logic r);
        bit [31:0] req;
        bit gok, aok;
        for (int i = 0; i < 32; i++) req[i] = (m_cnt[i] != 0);
        if ($countones(g) > 1 || (g != 0 && m_stall) || ((g & ~req) != 0)) m_gerr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            gok = g[i] && req[i] && !m_stall;
            aok = p[i] && (m_cnt[i] != 3 || gok);
            if (p[i] && !aok) m_ovf = 1'b1;
            if (aok && !gok) m_cnt[i]++;
            else if (gok && !aok) m_cnt[i]--;
        end
        m_stall = !r;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        int   sum;
        sum = 0;
        e.tag = tag;
        for (int i = 0; i < 32; i++) begin
            e.req[i]  = (m_cnt[i] != 0);
            e.full[i] = (m_cnt[i] == 3);
            sum += m_cnt[i];
        end
        e.tot   = 7'(sum);
        e.stall = m_stall;
        e.ovf   = m_ovf;
        e.gerr  = m_gerr;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".request"}, request, e.req);
            chk({e.tag, ".full"}, full, e.full);
            chk({e.tag, ".total"}, 32'(total_pending), 32'(e.tot));
            chk({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
            chk({e.tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
            chk({e.tag, ".grant_err"}, 32'(grant_err), 32'(e.gerr));
        end
    endtask

    task automatic cycle(input string tag, input logic [31:0] p, input logic [31:0] g, input logic r);
        post             = p;
        grant            = g;
        downstream_ready = r;
        model_step(p, g, r);
        push_exp(tag);
        @(posedge clk);
        #1;
        post  = '0;
        grant = '0;
        pop_cmp();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        post             = '0;
        grant            = '0;
        downstream_ready = 1'b1;
        model_reset();
        #12;
        chk("rst.request", request, 32'h0);
        chk("rst.full", full, 32'h0);
        chk("rst.total", 32'(total_pending), 32'd0);
        chk("rst.stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel.stall_first", 32'(stall), 32'd1);

        // idle: stall falls after the first edge with ready high
        cycle("idle0", 32'h0, 32'h0, 1'b1);
        chk("idle.stall_second", 32'(stall), 32'd0);
        cycle("idle1", 32'h0, 32'h0, 1'b1);

        // single client round trip
        cycle("post5", 32'h20, 32'h0, 1'b1);
        chk("post5.req_const", request, 32'h20);
        chk("post5.tot_const", 32'(total_pending), 32'd1);
        cycle("grant5", 32'h0, 32'h20, 1'b1);
        chk("grant5.req_const", request, 32'h0);
        chk("grant5.err_const", 32'(grant_err), 32'd0);

        // saturation of client 0
        for (int k = 0; k < 3; k++) cycle("sat", 32'h1, 32'h0, 1'b1);
        chk("sat3.ovf_const", 32'(overflow), 32'd0);
        chk("sat3.full_const", full, 32'h1);
        cycle("sat4", 32'h1, 32'h0, 1'b1);
        chk("sat4.ovf_const", 32'(overflow), 32'd1);
        chk("sat4.tot_const", 32'(total_pending), 32'd3);
        cycle("post_grant_full", 32'h1, 32'h1, 1'b1);
        chk("pg.tot_const", 32'(total_pending), 32'd3);
        chk("pg.full_const", full, 32'h1);
        for (int k = 0; k < 3; k++) cycle("drain0", 32'h0, 32'h1, 1'b1);
        chk("drain0.tot_const", 32'(total_pending), 32'd0);

        // all clients then stall gating
        cycle("post_all", 32'hFFFF_FFFF, 32'h0, 1'b1);
        chk("all.tot_const", 32'(total_pending), 32'd32);
        for (int k = 0; k < 3; k++) cycle("stalled", 32'h0, 32'h0, 1'b0);
        chk("stalled.stall_const", 32'(stall), 32'd1);
        chk("stalled.req_const", request, 32'hFFFF_FFFF);
        cycle("unstall", 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 32; k++) cycle("drain_all", 32'h0, 32'h1 << k, 1'b1);
        chk("drain_all.req_const", request, 32'h0);

        // grant protocol: two bits, only bit 2 valid
        cycle("post2", 32'h4, 32'h0, 1'b1);
        cycle("grant6", 32'h0, 32'h6, 1'b1);
        chk("grant6.err_const", 32'(grant_err), 32'd1);
        chk("grant6.tot_const", 32'(total_pending), 32'd0);

        // grant while stalled must not retire the request
        do_reset();
        cycle("stall_post2", 32'h4, 32'h0, 1'b0);
        chk("stall_post2.err_const", 32'(grant_err), 32'd0);
        cycle("stall_grant4", 32'h0, 32'h4, 1'b0);
        chk("stall_grant4.err_const", 32'(grant_err), 32'd1);
        chk("stall_grant4.tot_const", 32'(total_pending), 32'd1);
        cycle("resume", 32'h0, 32'h0, 1'b1);
        cycle("retire2", 32'h0, 32'h4, 1'b1);

        // build ten pending requests, with overflow set, then reset between edges
        cycle("post_ff", 32'hFF, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) cycle("post0_more", 32'h1, 32'h0, 1'b1);
        chk("ten.tot_const", 32'(total_pending), 32'd10);
        chk("ten.ovf_const", 32'(overflow), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async.request", request, 32'h0);
        chk("async.total", 32'(total_pending), 32'd0);
        chk("async.stall", 32'(stall), 32'd1);
        chk("async.overflow", 32'(overflow), 32'd0);
        chk("async.grant_err", 32'(grant_err), 32'd0);
        chk("async.sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/req_collector.md
# req_collector

Per-client request accumulator that sits directly upstream of `rr_arbiter`. It turns single-cycle `post` pulses from up to CLIENTS clients into the level `request` vector the arbiter consumes. Each client's pending count is retired only when that client is granted, and the block drives the arbiter's `stall` from downstream readiness. It also checks the returned `grant` vector for protocol violations.

## Interface
- CLIENTS, 32, number of clients; matches the arbiter's CLIENTS.
- CNT_W, 2, per-client pending-counter width; MAX_PEND = 2^CNT_W-1 (3 by default).
- TOT_W, $clog2(CLIENTS*MAX_PEND+1), width of `total_pending` (7 by default).

- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
- post  in  CLIENTS  per-client new-request pulse; one pending request is added per cycle the bit is high.
- full  out  CLIENTS  client i has MAX_PEND requests pending; combinational from count[i].
- request  out  CLIENTS  to arbiter; request[i] = (count[i] != 0).
- grant  in  CLIENTS  from arbiter; consumed in the same cycle it is presented.
- downstream_ready  in  1  consumer of granted work can accept this cycle.
- stall  out  1  to arbiter; registered.
- total_pending  out  TOT_W  sum of all count[i]; registered.
- overflow  out  1  sticky: a `post` arrived while `full` was high.
- grant_err  out  1  sticky: protocol violation on `grant`.

## Operation
- State per client: count[i] is a CNT_W-bit register. Global state: stall, total_pending, overflow, grant_err.
- Reset values:
  - count = 0, so request = 0 and full = 0.
  - stall = 1.
  - total_pending = 0, overflow = 0, grant_err = 0.
- Valid grant: g_ok[i] = grant[i] & request[i] & ~stall.
- Accept: a_ok[i] = post[i] & (~full[i] | g_ok[i]).
  - A post to a full client is accepted if the same client is granted in that cycle.
- Count update per cycle:
  - a_ok & ~g_ok: count+1.
  - g_ok & ~a_ok: count-1.
  - both or neither: count unchanged.
- Counts never wrap: they never exceed MAX_PEND and never drop below 0.
- Dropped post: post[i] & ~a_ok[i] discards the request and sets overflow.
- Request stability: request[i], once high, stays high until a cycle with g_ok[i] that brings the count to 0. It never drops without a grant.
- total_pending next = total_pending + popcount(a_ok) - popcount(g_ok). At all times it equals the sum of the counts.
- stall next = ~downstream_ready.
- grant_err is set at posedge if any of the following holds:
  - more than one grant bit is high;
  - grant != 0 while stall = 1;
  - grant[i] = 1 while request[i] = 0.
- Invalid grant bits (stall high, or idle client) never change count.
- When more than one grant bit is high, every bit with g_ok = 1 still decrements its count.
- overflow and grant_err clear only on reset.

## Timing
- post to request: 1 cycle. A post at edge N produces request[i] = 1 from N+1.
- Grant to request drop: request drops 1 cycle after the grant that retires the last pending request.
- downstream_ready to stall: 1 cycle.
- First cycle after reset deassertion: stall = 1. The earliest possible grant is the second edge after reset release, and only if downstream_ready was high at the first.
- full, request: pure functions of registered count; no combinational path from post or grant.
- Reset asserted mid-operation: all pending requests are discarded immediately and asynchronously; outputs go to their reset values without waiting for a clock.

## Test plan
- Reset and idle:
  - Stimulus: hold reset low, then release with post = 0 and downstream_ready = 1.
  - Required: request = 0, full = 0, total_pending = 0. stall = 1 in the first cycle, then 0 from the second cycle on.
- Single client round trip:
  - Stimulus: post[5] pulsed once; then grant = 32'h20 for one cycle while stall = 0.
  - Required: request = 32'h20 one cycle after the post; total_pending = 1. request = 0 and total_pending = 0 one cycle after the grant. No error flags set.
- Saturation and simultaneous post/grant:
  - Stimulus: post[0] high for 4 consecutive cycles with no grant.
  - Required: count[0] = 3, full[0] = 1, overflow = 1 on the fourth post.
  - Stimulus: then post[0] and grant = 32'h1 in the same cycle.
  - Required: count[0] stays 3, full[0] stays 1, and this post does not set overflow.
- All clients, stall gating:
  - Stimulus: post = 32'hFFFF_FFFF for 1 cycle; then downstream_ready = 0 for 3 cycles while grant = 0.
  - Required: request = 32'hFFFF_FFFF, total_pending = 32, stall = 1 one cycle after ready drops. Counts are unchanged throughout.
- Grant protocol errors:
  - Stimulus: with only client 2 pending, drive grant = 32'h6; separately, drive grant = 32'h4 while stall = 1.
  - Required: grant_err = 1 after each case. count[1] stays 0. count[2] is decremented only in the valid case (stall = 0, bit 2 high).
- Reset mid-operation:
  - Stimulus: with total_pending = 10, assert reset between clock edges.
  - Required: request = 0, total_pending = 0, stall = 1, overflow = 0, grant_err = 0 immediately, without waiting for a clock edge.
